// File: rtl/sum_of_squares_seq.sv
// sum_of_squares_seq
//   Accepts a vector of LEN unsigned W-bit elements, one per handshake. Each
//   element is squared by a radix-2 shift-add multiplier (one multiplier bit
//   per cycle). The square is added into an N-bit saturating accumulator.
//   When the last element has been added, the result is registered on O and
//   ready is raised. ready, O and sat then hold until the next start.
//
// Parameters
//   W    element width in bits
//   LEN  elements per vector (2..16)
//   N    result width (even, so O can drive an N-bit square-root input)
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   start      begin a vector (sampled only in IDLE)
//   din        vector element
//   din_valid  din holds a valid element
//   din_ready  block accepts din this cycle (high only in LOAD)
//   O          registered sum of squares
//   sat        accumulation saturated (sticky until next start)
//   ready      O and sat are valid
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for start; result outputs hold the last vector
// LOAD  | din_ready high, waiting for din_valid to capture an element
// MULT  | W shift-add steps forming din*din
// ACC   | add square into accumulator with saturation, count element
// DONE  | register result, raise ready
module sum_of_squares_seq #(
    parameter int W   = 8,
    parameter int LEN = 4,
    parameter int N   = 2*W+4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] din,
    input  logic         din_valid,
    output logic         din_ready,
    output logic [N-1:0] O,
    output logic         sat,
    output logic         ready
);

    localparam int PW = 2*W;
    // The sum is wide enough for both the accumulator and the full product,
    // plus one carry bit. Any bit at or above N means the sum overflowed.
    localparam int SW = ((N > PW) ? N : PW) + 1;
    localparam int CW = $clog2(LEN);
    localparam int BW = $clog2(W+1);
    localparam logic [CW-1:0] LAST_ELEM = CW'(LEN-1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(W-1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        MULT = 3'd2,
        ACC  = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t state, next_state;

    logic [N-1:0]  acc;
    logic [CW-1:0] count;
    logic [PW-1:0] product;
    logic [PW-1:0] mcand;
    logic [W-1:0]  mplier;
    logic [BW-1:0] bit_cnt;
    logic [SW-1:0] acc_sum;
    logic          overflow;

    logic clr_en;
    logic load_en;
    logic mult_en;
    logic acc_en;
    logic done_en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        clr_en     = 1'b0;
        load_en    = 1'b0;
        mult_en    = 1'b0;
        acc_en     = 1'b0;
        done_en    = 1'b0;
        din_ready  = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    clr_en     = 1'b1;
                    next_state = LOAD;
                end
            end
            LOAD: begin
                din_ready = 1'b1;
                if (din_valid) begin
                    load_en    = 1'b1;
                    next_state = MULT;
                end
            end
            MULT: begin
                mult_en = 1'b1;
                if (bit_cnt == LAST_BIT) begin
                    next_state = ACC;
                end
            end
            ACC: begin
                acc_en = 1'b1;
                if (count == LAST_ELEM) begin
                    next_state = DONE;
                end else begin
                    next_state = LOAD;
                end
            end
            DONE: begin
                done_en    = 1'b1;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    assign acc_sum  = SW'(acc) + SW'(product);
    assign overflow = |acc_sum[SW-1:N];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc     <= '0;
            count   <= '0;
            product <= '0;
            mcand   <= '0;
            mplier  <= '0;
            bit_cnt <= '0;
            O       <= '0;
            sat     <= 1'b0;
            ready   <= 1'b0;
        end else begin
            if (clr_en) begin
                acc   <= '0;
                count <= '0;
                sat   <= 1'b0;
                ready <= 1'b0;
            end
            if (load_en) begin
                mcand   <= PW'(din);
                mplier  <= din;
                product <= '0;
                bit_cnt <= '0;
            end
            // One multiplier bit per cycle: add the shifted multiplicand when
            // the current LSB of the multiplier is set.
            if (mult_en) begin
                if (mplier[0]) begin
                    product <= product + mcand;
                end
                mcand   <= mcand << 1;
                mplier  <= mplier >> 1;
                bit_cnt <= bit_cnt + BW'(1);
            end
            if (acc_en) begin
                if (overflow) begin
                    acc <= '1;
                    sat <= 1'b1;
                end else begin
                    acc <= acc_sum[N-1:0];
                end
                count <= count + CW'(1);
            end
            if (done_en) begin
                O     <= acc;
                ready <= 1'b1;
            end
        end
    end

endmodule

// File: doc/sum_of_squares_seq.md
SUM_OF_SQUARES_SEQ -- requirements
Module: sum_of_squares_seq

Interface
REQ-001 SHALL have parameter W, default 8: unsigned element width in bits.
REQ-002 SHALL have parameter LEN, default 4: elements per vector, legal range 2..16.
REQ-003 SHALL have parameter N, default 2*W+4: result width, even, so the result can drive an N-bit square-root A input.
REQ-004 SHALL have port clk, input, 1 bit: single clock, all state updates on the rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port start, input, 1 bit: begins a vector; sampled only in IDLE.
REQ-007 SHALL have port din, input, W bits: unsigned vector element.
REQ-008 SHALL have port din_valid, input, 1 bit: din holds a valid element.
REQ-009 SHALL have port din_ready, output, 1 bit: block accepts din this cycle.
REQ-010 SHALL have port O, output, N bits: registered sum of squares.
REQ-011 SHALL have port sat, output, 1 bit: the accumulation saturated.
REQ-012 SHALL have port ready, output, 1 bit: O and sat are valid.

Function
REQ-013 SHALL implement the states IDLE, LOAD, MULT, ACC and DONE.
REQ-014 SHALL, in IDLE with start=1, clear the accumulator, sat and element count, drive ready to 0, and enter LOAD.
REQ-015 SHALL ignore start in every state other than IDLE.
REQ-016 SHALL drive din_ready=1 only in LOAD, combinationally.
REQ-017 SHALL, in LOAD, capture din on a cycle with din_valid=1, clear the product register and bit counter, and enter MULT.
REQ-018 SHALL, in LOAD with din_valid=0, stay in LOAD with no limit.
REQ-019 SHALL, in MULT, compute din*din by radix-2 shift-add in exactly W cycles (one multiplier bit per cycle, 2W-bit product, no overflow), then enter ACC.
REQ-020 SHALL, in ACC, set acc = acc + product, zero-extended to N+1 bits.
REQ-021 SHALL, in ACC, when the sum exceeds 2^N-1, clamp acc to all ones and set sat (sticky until the next start).
REQ-022 SHALL, in ACC, increment count and enter DONE if count==LEN-1, else enter LOAD.
REQ-023 SHALL, in DONE, register O<=acc, keep sat, set ready<=1, and enter IDLE.
REQ-024 SHALL hold ready=1, O and sat stable in IDLE until the next accepted start; ready SHALL fall on the edge that accepts start.
REQ-025 SHALL, with din_valid held high, take LEN*(W+2)+2 rising edges from the edge that samples start to the edge that sets ready (42 for the defaults).
REQ-026 SHALL lengthen that latency by exactly the number of LOAD cycles spent with din_valid=0.
REQ-027 SHALL accept a start in the first cycle that ready is visible; back-to-back vectors are legal.
REQ-028 SHALL give an element value of 0 the same timing as any other value.

Reset
REQ-029 SHALL, on rst=1 and independent of clk, force state=IDLE, O=0, sat=0, ready=0, din_ready=0, and clear acc, count, product and bit counter.
REQ-030 SHALL, on rst asserted mid-operation (any state), abandon the vector with no partial result and no ready pulse.
REQ-031 SHALL require a fresh start after rst deasserts and SHALL NOT resume the abandoned vector.

Verification
REQ-032 Bench SHALL cover: defaults; start, then din 3,4,0,12 with din_valid high -> O=169, sat=0, ready rises at edge 42.
REQ-033 Bench SHALL cover: defaults; din 255 x4 -> O=260100, sat=0.
REQ-034 Bench SHALL cover: as REQ-032 but din_valid low for 5 cycles before the 2nd element -> din_ready stays high through the gap, O=169, ready at edge 47.
REQ-035 Bench SHALL cover: N=16 override; din 255 x4 -> O=65535, sat=1; the next vector 1,1,1,1 -> O=4, sat=0.
REQ-036 Bench SHALL cover: start pulsed again mid-MULT -> ignored, result unchanged; rst pulsed mid-MULT of the 3rd element -> O=0, ready=0, din_ready=0 at once; a new start with 2,2,2,2 -> O=16.
REQ-037 Bench SHALL cover: start asserted the cycle ready rises -> ready falls on that edge, the second result is correct, and the first O holds until the second DONE.
